// File: rtl/issue_unit.sv
// issue_unit -- in-order issue stage between the instruction queue and the
// reservation stations of the Tomasulo core.
//
// Pops one instruction from the queue, reads both source operands (value and
// dependency tag) from the register file, allocates the lowest free station
// of the instruction's class, and renames rd to that station tag. The CDB is
// snooped to free stations and to forward results into operands that are
// still waiting.
//
// Ports
//   CLK, CLR              clock, asynchronous active-low reset
//   vazio, rtr, instrOut  instruction queue: empty flag, pop pulse, head word
//   numR0/1, depR0/1,     register file read: address, tag (0 = ready),
//   dataR0/1              value
//   wren, numW, depW      rename write into the register file dependency field
//   cdbValid/Tag/Data     common data bus broadcast
//   rsWr, rsTag, rsOp,    reservation station write: strobe, station, operation,
//   rsVj/Vk, rsQj/Qk      operand values and tags (0 = ready)
//   rsBusy                station busy vector, bit i-1 = station i
//   err                   one-cycle pulse on an illegal opcode
module issue_unit (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        vazio,
    output logic        rtr,
    input  logic [15:0] instrOut,
    output logic [2:0]  numR0,
    output logic [2:0]  numR1,
    input  logic [2:0]  depR0,
    input  logic [2:0]  depR1,
    input  logic [15:0] dataR0,
    input  logic [15:0] dataR1,
    output logic        wren,
    output logic [2:0]  numW,
    output logic [2:0]  depW,
    input  logic        cdbValid,
    input  logic [2:0]  cdbTag,
    input  logic [15:0] cdbData,
    output logic        rsWr,
    output logic [2:0]  rsTag,
    output logic [1:0]  rsOp,
    output logic [15:0] rsVj,
    output logic [15:0] rsVk,
    output logic [2:0]  rsQj,
    output logic [2:0]  rsQk,
    output logic [4:0]  rsBusy,
    output logic        err
);
    typedef enum logic [1:0] {IDLE = 2'd0, LATCH = 2'd1, READ = 2'd2, ISSUE = 2'd3} state_t;

    state_t      state_reg, state_next;
    logic [15:3] ir_reg;            // bits [2:0] of the instruction carry nothing
    logic [4:0]  busy_reg;
    logic [2:0]  tag_hold_reg, rd_hold_reg;
    logic [1:0]  op_hold_reg;

    logic [3:0]  op;
    logic [2:0]  rd;
    logic        is_nop, is_add, is_mul, is_illegal;
    logic        cdb_live;
    logic [4:0]  cdb_clear, class_mask, alloc_onehot;
    logic [2:0]  alloc_tag;
    logic        in_issue, issue_fire, done, rtr_raw;
    logic [2:0]  dep_in [2];
    logic [15:0] data_in [2];
    logic [2:0]  out_q [2];
    logic [15:0] out_v [2];
    logic        unused_low;

    assign unused_low = ^instrOut[2:0];

    assign op    = ir_reg[15:12];
    assign rd    = ir_reg[11:9];
    assign numR0 = ir_reg[8:6];
    assign numR1 = ir_reg[5:3];

    assign is_nop     = (op == 4'd0);
    assign is_add     = (op == 4'd1) || (op == 4'd2);
    assign is_mul     = (op == 4'd3) || (op == 4'd4);
    assign is_illegal = !(is_nop || is_add || is_mul);

    // Tags 0, 6 and 7 never name a station, so such broadcasts are dropped.
    assign cdb_live   = cdbValid && (cdbTag >= 3'd1) && (cdbTag <= 3'd5);

    assign class_mask = is_add ? 5'b00111 : (is_mul ? 5'b11000 : 5'b00000);

    // Lowest free station of the class, judged on busy bits at cycle start:
    // a CDB free in this cycle only becomes allocatable next cycle.
    always_comb begin
        alloc_tag = 3'd0;
        for (int s = 5; s >= 1; s--) begin
            if (class_mask[s-1] && !busy_reg[s-1]) begin
                alloc_tag = 3'(s);
            end
        end
    end

    assign in_issue   = (state_reg == ISSUE);
    assign issue_fire = in_issue && (alloc_tag != 3'd0);
    assign done       = in_issue && (is_nop || is_illegal || issue_fire);

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_station
            assign cdb_clear[gi]    = cdb_live && (cdbTag == 3'(gi + 1));
            assign alloc_onehot[gi] = issue_fire && (alloc_tag == 3'(gi + 1));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        rtr_raw    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!vazio) begin
                    rtr_raw    = 1'b1;
                    state_next = LATCH;
                end
            end
            LATCH: state_next = READ;
            READ:  state_next = ISSUE;
            ISSUE: begin
                if (done) begin
                    if (!vazio) begin
                        rtr_raw    = 1'b1;
                        state_next = LATCH;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // rtr is combinational from state and vazio; masking with CLR keeps it
    // low while reset is held even if the queue is non-empty.
    assign rtr  = rtr_raw && CLR;
    assign err  = in_issue && is_illegal;
    assign rsWr = issue_fire;
    assign wren = issue_fire;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_reg    <= IDLE;
            ir_reg       <= '0;
            busy_reg     <= '0;
            tag_hold_reg <= '0;
            rd_hold_reg  <= '0;
            op_hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            // A station can only be re-allocated if it was free at cycle start,
            // so the set term never fights a same-cycle clear of a busy station.
            busy_reg  <= (busy_reg & ~cdb_clear) | alloc_onehot;
            if (state_reg == LATCH) begin
                ir_reg <= instrOut[15:3];
            end
            if (issue_fire) begin
                tag_hold_reg <= alloc_tag;
                rd_hold_reg  <= rd;
                op_hold_reg  <= op[1:0] - 2'd1;
            end
        end
    end

    assign dep_in[0]  = depR0;
    assign dep_in[1]  = depR1;
    assign data_in[0] = dataR0;
    assign data_in[1] = dataR1;

    // Per-source operand: captured in READ (with same-cycle CDB forwarding),
    // then kept current by snooping the CDB while the issue is stalled.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            logic [2:0]  q_reg, q_hold_reg;
            logic [15:0] v_reg, v_hold_reg;
            logic        read_hit, stall_hit;

            assign read_hit  = cdb_live && (dep_in[gi] != 3'd0) && (cdbTag == dep_in[gi]);
            assign stall_hit = cdb_live && (q_reg == cdbTag);

            always_ff @(posedge CLK or negedge CLR) begin
                if (!CLR) begin
                    q_reg      <= '0;
                    v_reg      <= '0;
                    q_hold_reg <= '0;
                    v_hold_reg <= '0;
                end else begin
                    if (state_reg == READ) begin
                        q_reg <= read_hit ? 3'd0 : dep_in[gi];
                        v_reg <= read_hit ? cdbData : data_in[gi];
                    end else if (in_issue && !done && stall_hit) begin
                        q_reg <= 3'd0;
                        v_reg <= cdbData;
                    end
                    if (issue_fire) begin
                        q_hold_reg <= q_reg;
                        v_hold_reg <= v_reg;
                    end
                end
            end

            assign out_q[gi] = issue_fire ? q_reg : q_hold_reg;
            assign out_v[gi] = issue_fire ? v_reg : v_hold_reg;
        end
    endgenerate

    assign rsTag  = issue_fire ? alloc_tag : tag_hold_reg;
    assign depW   = rsTag;
    assign numW   = issue_fire ? rd : rd_hold_reg;
    assign rsOp   = issue_fire ? (op[1:0] - 2'd1) : op_hold_reg;
    assign rsQj   = out_q[0];
    assign rsQk   = out_q[1];
    assign rsVj   = out_v[0];
    assign rsVk   = out_v[1];
    assign rsBusy = busy_reg;
endmodule
